instr_profile_ctrl: RTL and testbench
=====================================

INSTR_PROFILE_CTRL -- requirements
Module: instr_profile_ctrl

Interface
REQ-001 Parameter NUM_CTRS, default 11, SHALL be the number of profiler counters serviced.
REQ-002 Parameter CW, default 32, SHALL be the width of each counter and of output data.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_op  in  2  00 NOP, 01 START, 10 STOP, 11 SNAPSHOT.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-008 window_cycles  in  32  run length in cycles, sampled on START; 0 = unlimited.
REQ-009 ctr_in  in  NUM_CTRS*CW  live profiler counters; counter k at bits [k*CW +: CW].
REQ-010 prof_enable  out  1  profiler enable; low clears the profiler counters.
REQ-011 out_valid  out  1  snapshot word valid.
REQ-012 out_ready  in  1  consumer accepts word.
REQ-013 out_data  out  CW  snapshot word at out_index.
REQ-014 out_index  out  4  counter number of out_data.
REQ-015 out_last  out  1  high with out_valid when out_index = NUM_CTRS-1.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 run_cycles  out  32  cycles prof_enable was high in the current/latest run, saturating at 0xFFFFFFFF.

Function
REQ-018 States SHALL be IDLE, RUN, DUMP_STOP, DUMP_RUN.
REQ-019 cmd_ready SHALL be 1 in IDLE and RUN, and 0 in both DUMP states and in the RUN cycle in which window expiry occurs.
REQ-020 IDLE + START: next cycle RUN, prof_enable=1, run_cycles=0, window latched.
REQ-021 IDLE + STOP or NOP: accepted, no effect; IDLE + SNAPSHOT: go to DUMP_STOP streaming the held snapshot unchanged.
REQ-022 RUN: run_cycles SHALL increment by 1 every cycle prof_enable is high, including in DUMP_RUN.
REQ-023 RUN + STOP: at that edge snapshot <= ctr_in, prof_enable <= 0, state <= DUMP_STOP.
REQ-024 RUN + SNAPSHOT: at that edge snapshot <= ctr_in, prof_enable stays 1, state <= DUMP_RUN.
REQ-025 RUN + START: accepted, no effect (run not restarted).
REQ-026 Window expiry: latched window W != 0 and run_cycles = W-1 in RUN SHALL act as STOP; prof_enable is high for exactly W cycles.
REQ-027 Expiry reached during DUMP_RUN SHALL be deferred: prof_enable stays high; on the final dump handshake an auto-STOP (capture, prof_enable low, DUMP_STOP) SHALL occur on that same edge.
REQ-028 Instructions counted by the profiler at the capture edge itself are excluded from the snapshot.
REQ-029 Dump: out_valid=1 in DUMP states; out_index starts at 0; advances by 1 on each out_valid & out_ready; out_data, out_index stable while out_ready=0.
REQ-030 Handshake with out_last: DUMP_STOP -> IDLE, DUMP_RUN -> RUN (or per REQ-027); out_index returns to 0; out_valid 0 next cycle unless re-entering DUMP_STOP.
REQ-031 The snapshot register SHALL hold its value until the next capture; it is never modified by ctr_in outside capture edges.
REQ-032 run_cycles SHALL hold its value in IDLE until the next START.

Reset
REQ-033 rst=1 at an edge SHALL force: IDLE, prof_enable=0, out_valid=0, out_index=0, out_last=0, busy=0, run_cycles=0, snapshot all zeros, latched window 0; overrides any command or handshake in that cycle.
REQ-034 rst during DUMP or RUN SHALL abort the dump/run with no further output words.

Verification
REQ-035 Reset, then SNAPSHOT in IDLE, out_ready=1 -> 11 words of 0, indices 0..10, out_last on index 10, then IDLE.
REQ-036 START window=5, ctr_in constant 7 each -> prof_enable high exactly 5 cycles, run_cycles=5, auto dump of eleven 7s, back to IDLE, cmd_ready 0 in expiry cycle.
REQ-037 START window=0, SNAPSHOT after 10 cycles with ctr_in word k = k+100, out_ready toggled 1/0 -> words 100..110 in order, each held while ready low, then RUN with prof_enable still 1.
REQ-038 START window=4, SNAPSHOT at run_cycles=1, out_ready=0 for 20 cycles -> prof_enable stays high past 4 cycles; final handshake triggers auto-STOP and second 11-word dump.
REQ-039 rst asserted mid DUMP_STOP at out_index=3 -> next cycle out_valid=0, out_index=0, IDLE, snapshot zero.
REQ-040 START while in RUN at run_cycles=6 -> accepted, run_cycles continues 7, 8, ... with no restart.

Source files
------------

// File: rtl/instr_profile_ctrl_if.sv
// Command and snapshot-stream bundle for the instruction profiler controller.
// The master side issues commands and consumes the dump; the slave side is the controller.
interface instr_profile_ctrl_if #(
  parameter int CW = 32
);
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic          cmd_ready;
  logic [31:0]   window_cycles;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_data;
  logic [3:0]    out_index;
  logic          out_last;

  modport master (
    output cmd_valid, cmd_op, window_cycles, out_ready,
    input  cmd_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  cmd_valid, cmd_op, window_cycles, out_ready,
    output cmd_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/instr_profile_ctrl.sv
// Profiler run/window controller: captures counters into a snapshot and streams it one word per handshake.
// Commands act at the accepting edge; the dump holds out_data/out_index while out_ready is low.
module instr_profile_ctrl #(
  parameter int NUM_CTRS = 11,
  parameter int CW       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_profile_ctrl_if.slave    bus,
  input  logic [NUM_CTRS*CW-1:0] ctr_in,
  output logic                   prof_enable,
  output logic                   busy,
  output logic [31:0]            run_cycles
);
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RUN       = 2'd1;
  localparam logic [1:0] S_DUMP_STOP = 2'd2;
  localparam logic [1:0] S_DUMP_RUN  = 2'd3;

  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_SNAP  = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CTRS - 1);

  logic [1:0]    state_q, state_d;
  logic          prof_en_q, prof_en_d;
  logic [31:0]   run_q, run_d;
  logic [31:0]   window_q, window_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] snap_q [NUM_CTRS];
  logic [CW-1:0] snap_d [NUM_CTRS];

  logic capture, expired, cmd_fire, out_fire, last_word, dumping;

  // Stays true once reached so an expiry that lands inside DUMP_RUN is honoured at the final handshake.
  assign expired   = (window_q != '0) && (run_q >= window_q - 32'd1);
  assign dumping   = (state_q == S_DUMP_STOP) || (state_q == S_DUMP_RUN);
  assign last_word = (idx_q == LAST_IDX);

  assign bus.cmd_ready = (state_q == S_IDLE) || ((state_q == S_RUN) && !expired);
  assign bus.out_valid = dumping;
  assign bus.out_last  = dumping && last_word;
  assign bus.out_index = idx_q;
  assign bus.out_data  = snap_q[idx_q];

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign out_fire = dumping && bus.out_ready;

  assign prof_enable = prof_en_q;
  assign busy        = (state_q != S_IDLE);
  assign run_cycles  = run_q;

  always_comb begin
    state_d   = state_q;
    prof_en_d = prof_en_q;
    window_d  = window_q;
    idx_d     = idx_q;
    capture   = 1'b0;
    run_d     = (prof_en_q && (run_q != '1)) ? run_q + 32'd1 : run_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire && (bus.cmd_op == OP_START)) begin
          state_d   = S_RUN;
          prof_en_d = 1'b1;
          run_d     = '0;
          window_d  = bus.window_cycles;
        end else if (cmd_fire && (bus.cmd_op == OP_SNAP)) begin
          state_d = S_DUMP_STOP;
        end
      end
      S_RUN: begin
        if (expired || (cmd_fire && (bus.cmd_op == OP_STOP))) begin
          capture   = 1'b1;
          prof_en_d = 1'b0;
          state_d   = S_DUMP_STOP;
        end else if (cmd_fire && (bus.cmd_op == OP_SNAP)) begin
          capture = 1'b1;
          state_d = S_DUMP_RUN;
        end
      end
      S_DUMP_STOP: begin
        if (out_fire) begin
          idx_d = last_word ? 4'd0 : idx_q + 4'd1;
          if (last_word) state_d = S_IDLE;
        end
      end
      default: begin
        if (out_fire) begin
          idx_d = last_word ? 4'd0 : idx_q + 4'd1;
          if (last_word && expired) begin
            capture   = 1'b1;
            prof_en_d = 1'b0;
            state_d   = S_DUMP_STOP;
          end else if (last_word) begin
            state_d = S_RUN;
          end
        end
      end
    endcase

    for (int k = 0; k < NUM_CTRS; k++) begin
      snap_d[k] = capture ? ctr_in[k*CW +: CW] : snap_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      prof_en_q <= 1'b0;
      run_q     <= '0;
      window_q  <= '0;
      idx_q     <= '0;
      for (int k = 0; k < NUM_CTRS; k++) snap_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      prof_en_q <= prof_en_d;
      run_q     <= run_d;
      window_q  <= window_d;
      idx_q     <= idx_d;
      for (int k = 0; k < NUM_CTRS; k++) snap_q[k] <= snap_d[k];
    end
  end
endmodule

// File: tb/tb_instr_profile_ctrl.sv
// Directed bench for instr_profile_ctrl: reset, windowed runs, live snapshots, deferred expiry, abort.
module tb_instr_profile_ctrl;
  localparam int N  = 11;
  localparam int CW = 32;
  localparam logic [1:0] OP_NOP = 2'd0, OP_START = 2'd1, OP_STOP = 2'd2, OP_SNAP = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*CW-1:0] ctr_in;
  logic          prof_enable;
  logic          busy;
  logic [31:0]   run_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_profile_ctrl_if #(.CW(CW)) bus ();

  instr_profile_ctrl #(.NUM_CTRS(N), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ctr_in      (ctr_in),
    .prof_enable (prof_enable),
    .busy        (busy),
    .run_cycles  (run_cycles)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctr(input int base, input int mul);
    for (int k = 0; k < N; k++) ctr_in[k*CW +: CW] = 32'(base + mul * k);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] win);
    bus.cmd_valid     = 1'b1;
    bus.cmd_op        = op;
    bus.window_cycles = win;
    tick();
    bus.cmd_valid     = 1'b0;
    bus.cmd_op        = OP_NOP;
  endtask

  // Consumes a full dump with out_ready held high; word k must equal base + mul*k.
  task automatic dump_check(input string tag, input int base, input int mul);
    bus.out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_valid%0d", tag, k), 64'(bus.out_valid), 64'd1);
      check($sformatf("%s_index%0d", tag, k), 64'(bus.out_index), 64'(k));
      check($sformatf("%s_data%0d", tag, k), 64'(bus.out_data), 64'(32'(base + mul * k)));
      check($sformatf("%s_last%0d", tag, k), 64'(bus.out_last), 64'(k == N - 1));
      tick();
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.cmd_valid     = 1'b0;
    bus.cmd_op        = OP_NOP;
    bus.window_cycles = '0;
    bus.out_ready     = 1'b0;
    set_ctr(0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_prof", 64'(prof_enable), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_index", 64'(bus.out_index), 64'd0);
    check("rst_last", 64'(bus.out_last), 64'd0);
    check("rst_run", 64'(run_cycles), 64'd0);
    check("rst_ready", 64'(bus.cmd_ready), 64'd1);

    // Snapshot from IDLE streams the zeroed snapshot
    send_cmd(OP_SNAP, 32'd0);
    dump_check("idle_snap", 0, 0);
    check("idle_snap_busy", 64'(busy), 64'd0);
    check("idle_snap_valid", 64'(bus.out_valid), 64'd0);

    // Window of 5: enable high exactly 5 cycles, auto dump of 7s
    set_ctr(7, 0);
    send_cmd(OP_START, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("win5_prof%0d", i), 64'(prof_enable), 64'd1);
      check($sformatf("win5_run%0d", i), 64'(run_cycles), 64'(i));
      check($sformatf("win5_cmdrdy%0d", i), 64'(bus.cmd_ready), 64'(i != 4));
      tick();
    end
    check("win5_prof_off", 64'(prof_enable), 64'd0);
    check("win5_run_final", 64'(run_cycles), 64'd5);
    check("win5_busy", 64'(busy), 64'd1);
    dump_check("win5_dump", 7, 0);
    check("win5_idle", 64'(busy), 64'd0);
    send_cmd(OP_STOP, 32'd0);
    check("idle_stop_busy", 64'(busy), 64'd0);
    check("idle_run_hold", 64'(run_cycles), 64'd5);

    // Unlimited run, ignored re-START, live snapshot with toggling ready
    set_ctr(100, 1);
    bus.out_ready = 1'b0;
    send_cmd(OP_START, 32'd0);
    repeat (6) tick();
    check("run6", 64'(run_cycles), 64'd6);
    check("run6_cmdrdy", 64'(bus.cmd_ready), 64'd1);
    send_cmd(OP_START, 32'd3);
    check("restart_ignored", 64'(run_cycles), 64'd7);
    tick();
    check("run8", 64'(run_cycles), 64'd8);
    repeat (2) tick();
    check("run10_prof", 64'(prof_enable), 64'd1);
    send_cmd(OP_SNAP, 32'd0);
    check("live_run11", 64'(run_cycles), 64'd11);
    check("live_cmdrdy", 64'(bus.cmd_ready), 64'd0);
    for (int k = 0; k < N; k++) begin
      bus.out_ready = 1'b0;
      check($sformatf("live_data%0d", k), 64'(bus.out_data), 64'(100 + k));
      tick();
      check($sformatf("live_hold_idx%0d", k), 64'(bus.out_index), 64'(k));
      check($sformatf("live_hold_data%0d", k), 64'(bus.out_data), 64'(100 + k));
      check($sformatf("live_last%0d", k), 64'(bus.out_last), 64'(k == N - 1));
      bus.out_ready = 1'b1;
      tick();
    end
    check("live_back_busy", 64'(busy), 64'd1);
    check("live_back_valid", 64'(bus.out_valid), 64'd0);
    check("live_back_prof", 64'(prof_enable), 64'd1);
    check("live_back_run", 64'(run_cycles), 64'd33);
    check("live_back_cmdrdy", 64'(bus.cmd_ready), 64'd1);
    send_cmd(OP_STOP, 32'd0);
    check("stop_prof", 64'(prof_enable), 64'd0);
    check("stop_run", 64'(run_cycles), 64'd34);
    dump_check("stop_dump", 100, 1);
    check("stop_idle", 64'(busy), 64'd0);

    // Window of 4 expiring inside a stalled live dump
    set_ctr(1, 3);
    bus.out_ready = 1'b0;
    send_cmd(OP_START, 32'd4);
    tick();
    check("defer_run1", 64'(run_cycles), 64'd1);
    send_cmd(OP_SNAP, 32'd0);
    set_ctr(50, 1);
    repeat (20) tick();
    check("defer_prof_hi", 64'(prof_enable), 64'd1);
    check("defer_run22", 64'(run_cycles), 64'd22);
    check("defer_idx0", 64'(bus.out_index), 64'd0);
    check("defer_cmdrdy", 64'(bus.cmd_ready), 64'd0);
    dump_check("defer_dump1", 1, 3);
    set_ctr(200, 0);
    check("auto_stop_prof", 64'(prof_enable), 64'd0);
    check("auto_stop_run", 64'(run_cycles), 64'd33);
    check("auto_stop_busy", 64'(busy), 64'd1);
    dump_check("defer_dump2", 50, 1);
    check("defer_idle", 64'(busy), 64'd0);
    check("defer_run_hold", 64'(run_cycles), 64'd33);

    // Reset in the middle of DUMP_STOP
    bus.out_ready = 1'b1;
    send_cmd(OP_SNAP, 32'd0);
    repeat (3) tick();
    check("abort_idx3", 64'(bus.out_index), 64'd3);
    check("abort_data3", 64'(bus.out_data), 64'd53);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_index", 64'(bus.out_index), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_run", 64'(run_cycles), 64'd0);
    check("abort_prof", 64'(prof_enable), 64'd0);
    send_cmd(OP_SNAP, 32'd0);
    dump_check("abort_snap_zero", 0, 0);
    check("abort_final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
